// File: rtl/synth_cmd_controller.sv
// UART command parser for the synth voice: decodes 4-byte frames
// (SYNC, CMD, DATA, CHK) into ADSR registers, note strobes and a gate level.
// Bad checksums, unknown commands, out-of-range notes and inter-byte timeouts
// are rejected and counted.
module synth_cmd_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] attack_time,
    output logic [7:0] decay_time,
    output logic [7:0] sustain_level,
    output logic [7:0] release_time,
    output logic [5:0] freq_select,
    output logic       note_on,
    output logic       note_off,
    output logic       gate,
    output logic       busy,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SyncByte  = 8'hA5;
    localparam logic [7:0] CmdAttack = 8'h01;
    localparam logic [7:0] CmdDecay  = 8'h02;
    localparam logic [7:0] CmdSus    = 8'h03;
    localparam logic [7:0] CmdRel    = 8'h04;
    localparam logic [7:0] CmdNoteOn = 8'h10;
    localparam logic [7:0] CmdNoteOf = 8'h11;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StChk} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      attack_q, attack_d;
    logic [7:0]      decay_q, decay_d;
    logic [7:0]      sustain_q, sustain_d;
    logic [7:0]      release_q, release_d;
    logic [5:0]      freq_q, freq_d;
    logic            gate_q, gate_d;
    logic            note_on_q, note_on_d;
    logic            note_off_q, note_off_d;
    logic            err_pulse_q, err_pulse_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            cmd_legal;
    logic            reject;

    // Command legality; note-on is only legal for the 48 supported notes.
    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_q)
            CmdAttack, CmdDecay, CmdSus, CmdRel, CmdNoteOf: cmd_legal = 1'b1;
            CmdNoteOn: cmd_legal = (data_q <= 8'd47);
            default:   cmd_legal = 1'b0;
        endcase
    end

    // Frame FSM, inter-byte timeout, commit and reject handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        attack_d    = attack_q;
        decay_d     = decay_q;
        sustain_d   = sustain_q;
        release_d   = release_q;
        freq_d      = freq_q;
        gate_d      = gate_q;
        note_on_d   = 1'b0;
        note_off_d  = 1'b0;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        reject      = 1'b0;

        if (state_q == StIdle) begin
            cnt_d = '0;
            if (rx_valid && rx_data == SyncByte) begin
                state_d = StCmd;
            end
        end else if (rx_valid) begin
            // A byte on the timeout cycle wins over the timeout.
            cnt_d = '0;
            unique case (state_q)
                StCmd: begin
                    cmd_d   = rx_data;
                    state_d = StData;
                end
                StData: begin
                    data_d  = rx_data;
                    state_d = StChk;
                end
                StChk: begin
                    state_d = StIdle;
                    if (cmd_legal && rx_data == (cmd_q ^ data_q)) begin
                        case (cmd_q)
                            CmdAttack: attack_d  = data_q;
                            CmdDecay:  decay_d   = data_q;
                            CmdSus:    sustain_d = data_q;
                            CmdRel:    release_d = data_q;
                            CmdNoteOn: begin
                                freq_d    = data_q[5:0];
                                gate_d    = 1'b1;
                                note_on_d = 1'b1;
                            end
                            CmdNoteOf: begin
                                if (gate_q) begin
                                    gate_d     = 1'b0;
                                    note_off_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (cnt_q == CntLast) begin
            state_d = StIdle;
            cnt_d   = '0;
            reject  = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (reject) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State and output registers; reset drops any partial frame silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            attack_q    <= '0;
            decay_q     <= '0;
            sustain_q   <= '0;
            release_q   <= '0;
            freq_q      <= '0;
            gate_q      <= 1'b0;
            note_on_q   <= 1'b0;
            note_off_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            attack_q    <= attack_d;
            decay_q     <= decay_d;
            sustain_q   <= sustain_d;
            release_q   <= release_d;
            freq_q      <= freq_d;
            gate_q      <= gate_d;
            note_on_q   <= note_on_d;
            note_off_q  <= note_off_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign attack_time   = attack_q;
    assign decay_time    = decay_q;
    assign sustain_level = sustain_q;
    assign release_time  = release_q;
    assign freq_select   = freq_q;
    assign gate          = gate_q;
    assign note_on       = note_on_q;
    assign note_off      = note_off_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: doc/synth_cmd_controller.md
SYNTH_CMD_CONTROLLER -- requirements
Module: synth_cmd_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 250000, inter-byte timeout in clk cycles (10 ms at 25 MHz).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  received UART byte, valid only when rx_valid=1.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe per received byte.
REQ-006 SHALL have ports attack_time, decay_time, sustain_level, release_time  output  8 each  ADSR parameter registers.
REQ-007 SHALL have port freq_select  output  6  note index, 0..47.
REQ-008 SHALL have port note_on  output  1  one-cycle note start strobe.
REQ-009 SHALL have port note_off  output  1  one-cycle note release strobe.
REQ-010 SHALL have port gate  output  1  level, 1 while a note is held.
REQ-011 SHALL have port busy  output  1  1 while a frame is partially received.
REQ-012 SHALL have port err_pulse  output  1  one-cycle strobe per rejected frame.
REQ-013 SHALL have port err_count  output  8  saturating count of rejected frames.

Function
REQ-014 SHALL parse 4-byte frames: SYNC=0xA5, CMD, DATA, CHK, where the required CHK = CMD XOR DATA.
REQ-015 SHALL implement FSM states IDLE, CMD, DATA, CHK, with busy=1 in every state except IDLE.
REQ-016 In IDLE, an rx_valid byte equal to 0xA5 SHALL move the FSM to CMD; any other byte SHALL be discarded with no error.
REQ-017 In CMD and DATA, any rx_valid byte (0xA5 included) SHALL be latched, moving the FSM to DATA and then CHK respectively.
REQ-018 In CHK, the rx_valid byte SHALL be evaluated and the FSM SHALL return to IDLE on the same edge.
REQ-019 Commit SHALL require a checksum match and a legal command: 0x01 attack_time=DATA; 0x02 decay_time=DATA; 0x03 sustain_level=DATA; 0x04 release_time=DATA; 0x10 note-on; 0x11 note-off.
REQ-020 Note-on SHALL be legal only if DATA<=47; then freq_select=DATA[5:0], gate=1 and note_on=1 for one cycle.
REQ-021 Note-on while gate=1 SHALL retrigger: freq_select updated, note_on pulsed, gate held at 1, no note_off.
REQ-022 Note-off with gate=1 SHALL set gate=0 and pulse note_off for one cycle; with gate=0 it SHALL be a no-op with no error; its DATA SHALL be ignored.
REQ-023 Committed register changes and strobes SHALL be visible immediately after the edge that samples CHK (latency 1 edge).
REQ-024 Checksum mismatch, unknown CMD, or note-on with DATA>47 SHALL reject the frame: no register change, err_pulse=1 for one cycle, err_count+1.
REQ-025 err_count SHALL saturate at 255; err_pulse SHALL still assert at saturation.
REQ-026 A timeout counter SHALL run in non-IDLE states, clear on each accepted byte, and be held at 0 in IDLE.
REQ-027 When the counter reaches TIMEOUT_CYCLES with no rx_valid, the FSM SHALL return to IDLE and the frame SHALL be rejected per REQ-024.
REQ-028 rx_valid coincident with the timeout cycle SHALL take priority: the byte is processed and no timeout occurs.
REQ-029 rx_valid SHALL be ignored on any cycle it is not asserted; back-to-back strobes on consecutive cycles SHALL each be accepted.

Reset
REQ-030 While rst_n=0: FSM=IDLE, timeout counter=0; ADSR registers, freq_select, gate, note_on, note_off, busy, err_pulse and err_count all 0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no err_pulse; reset with gate=1 SHALL clear gate without a note_off pulse.

Verification
REQ-032 Bytes A5,01,40,41 -> attack_time=0x40 after the 4th byte; no err_pulse; busy 1 from byte 1 through byte 3.
REQ-033 Bytes A5,10,21,31 -> freq_select=33, gate=1, note_on pulse for one cycle; then A5,11,00,11 -> gate=0, note_off pulse.
REQ-034 Bytes A5,03,80,00 (bad CHK) -> sustain_level unchanged, err_pulse for one cycle, err_count=1; then A5,10,30,20 (DATA=48) -> rejected, err_count=2.
REQ-035 Bytes A5,02 then no byte for TIMEOUT_CYCLES (bench sets 100) -> FSM returns to IDLE, err_pulse; next frame A5,02,10,12 -> decay_time=0x10.
REQ-036 Bytes 00,FF,A5,04,A5,A1 -> leading bytes ignored, release_time=0xA5; 300 bad frames -> err_count=255.
REQ-037 rst_n pulsed low after A5,01 with gate=1 -> all outputs 0, no pulses; a following A5,01,05,04 frame commits normally.
